conversor_periodo_bcd: RTL and testbench

Downstream consumer of the period counter.
- Captures the 32-bit millisecond period on the counter's done pulse.
- Converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- Presents stable digits plus a leading-zero blanking mask for the display driver.
- Saturates values that do not fit in DIGITS decimal digits.

---
 rtl/conversor_periodo_bcd.sv | 145 ++++++++++++++
 tb/tb_conversor_periodo_bcd.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_periodo_bcd.sv
// -----------------------------------------------------------------------------
// conversor_periodo_bcd
//
// Captures a binary millisecond period from the period counter and converts
// it to packed BCD for a display driver. It uses a sequential shift-add-3
// (double-dabble) engine that processes one input bit per cycle. Values that
// do not fit in DIGITS decimal digits saturate to all nines and set overflow.
//
// Handshake: a sample is accepted on any rising edge where in_valid=1 and
// ready=1. ready is high only in IDLE, and busy is its exact complement.
// If in_valid arrives while busy, the sample is discarded and drop pulses for
// one cycle. out_valid pulses for one cycle when bcd/digit_en/overflow update.
// Those three outputs hold their value until the next update or until reset.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_valid      capture strobe (counter done)
//   in_periodo_ms period in ms, sampled when in_valid & ready
//   ready         idle, able to accept in_valid
//   busy          conversion in progress (~ready)
//   out_valid     one-cycle result strobe
//   bcd           packed BCD result, digit 0 in bits [3:0]
//   digit_en      significant-digit mask, bit 0 always 1
//   overflow      last captured value exceeded 10^DIGITS-1
//   drop          one-cycle pulse when a sample was discarded
// -----------------------------------------------------------------------------
module conversor_periodo_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_periodo_ms,
  output logic                  ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  overflow,
  output logic                  drop
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin_sr;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   iter;
  logic               pending_ovf;

  logic [ACC_W-1:0]   acc_adj;
  logic [DIGITS-1:0]  en_calc;
  logic [3:0]         digit;
  logic               seen;

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // Add-3 correction: each digit is adjusted independently, with no carry
  // between digits.
  always_comb begin
    acc_adj = '0;
    digit   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = acc[4*k +: 4];
      acc_adj[4*k +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  end

  // A digit is significant if it or any higher digit is nonzero. The units
  // digit is always shown, so that zero displays as "0".
  always_comb begin
    en_calc = '0;
    seen    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen       = seen | (acc[4*k +: 4] != 4'd0);
      en_calc[k] = seen;
    end
    en_calc[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bin_sr      <= '0;
      acc         <= '0;
      iter        <= '0;
      pending_ovf <= 1'b0;
      out_valid   <= 1'b0;
      drop        <= 1'b0;
      bcd         <= '0;
      digit_en    <= DIGITS'(1);
      overflow    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      drop      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_periodo_ms > MAX_VAL) begin
              bin_sr      <= MAX_VAL;
              pending_ovf <= 1'b1;
            end else begin
              bin_sr      <= in_periodo_ms;
              pending_ovf <= 1'b0;
            end
            acc   <= '0;
            iter  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The clamp keeps the result below 10^DIGITS, so the accumulator
          // MSB is always zero before the shift and no bit is lost.
          acc    <= {acc_adj[ACC_W-2:0], bin_sr[WIDTH-1]};
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          iter   <= iter + CNT_W'(1);
          if (iter == LAST_ITER) state <= FINISH;
          if (in_valid) drop <= 1'b1;
        end
        FINISH: begin
          bcd       <= acc;
          overflow  <= pending_ovf;
          digit_en  <= en_calc;
          out_valid <= 1'b1;
          state     <= IDLE;
          if (in_valid) drop <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_periodo_bcd.sv
// -----------------------------------------------------------------------------
// Testbench for conversor_periodo_bcd (WIDTH=32, DIGITS=6).
// The driver pushes {overflow, digit_en, bcd} and the expected out_valid cycle
// into queues. A negedge monitor pops these entries and compares them
// whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_conversor_periodo_bcd;

  localparam int W  = 32;
  localparam int D  = 6;
  localparam int EW = 1 + D + 4 * D;
  localparam logic [EW-1:0] RESET_VAL = {1'b0, 6'b000001, 24'h000000};

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [W-1:0]    in_periodo_ms;
  logic            ready;
  logic            busy;
  logic            out_valid;
  logic [4*D-1:0]  bcd;
  logic [D-1:0]    digit_en;
  logic            overflow;
  logic            drop;

  conversor_periodo_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_periodo_ms (in_periodo_ms),
    .ready         (ready),
    .busy          (busy),
    .out_valid     (out_valid),
    .bcd           (bcd),
    .digit_en      (digit_en),
    .overflow      (overflow),
    .drop          (drop)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [EW-1:0] held = RESET_VAL;
  int checks     = 0;
  int failures   = 0;
  int drops_seen = 0;
  int drops_exp  = 0;
  int outs_seen  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            ec;
    if (!rst) begin
      chk("busy_not_ready", {busy, ready}, {~ready, ready});
      if (drop) drops_seen++;
      if (out_valid) begin
        outs_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {overflow, digit_en, bcd}, '1);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("result", {overflow, digit_en, bcd}, e);
          chk("latency_cycle", cyc, ec);
          held = e;
        end
      end else begin
        chk("held_outputs", {overflow, digit_en, bcd}, held);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] v, input logic [EW-1:0] e);
    int n = 0;
    @(posedge clk); #1;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready_timeout", ready, 1'b1);
    in_valid      = 1'b1;
    in_periodo_ms = v;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 34);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_periodo_ms = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready",     ready,     1'b1);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_drop",      drop,      1'b0);
    chk("rst_outputs",   {overflow, digit_en, bcd}, RESET_VAL);

    // zero
    send(32'd0, {1'b0, 6'b000001, 24'h000000});
    wait_drain();

    // 1000 with ready-window measurement
    send(32'd1000, {1'b0, 6'b001111, 24'h001000});
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_low_cycles", n, 33);
    wait_drain();

    // back-to-back on the first ready cycle
    send(32'd123456, {1'b0, 6'b111111, 24'h123456});
    send(32'd999999, {1'b0, 6'b111111, 24'h999999});
    wait_drain();

    // saturation
    send(32'd1000000,    {1'b1, 6'b111111, 24'h999999});
    send(32'hFFFF_FFFF,  {1'b1, 6'b111111, 24'h999999});
    wait_drain();

    // input arriving during a conversion is dropped
    send(32'd4321, {1'b0, 6'b001111, 24'h004321});
    repeat (9) begin @(posedge clk); #1; end
    in_valid      = 1'b1;
    in_periodo_ms = 32'd7;
    drops_exp++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drop_pulse", drop, 1'b1);
    @(posedge clk); #1;
    chk("drop_clear", drop, 1'b0);
    wait_drain();

    // reset in the middle of a conversion
    send(32'd555, {1'b0, 6'b000111, 24'h000555});
    repeat (14) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    held = RESET_VAL;
    #1;
    chk("midrst_outputs", {overflow, digit_en, bcd}, RESET_VAL);
    chk("midrst_ready",   ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    chk("post_rst_ready", ready, 1'b1);
    send(32'd555, {1'b0, 6'b000111, 24'h000555});
    wait_drain();

    repeat (3) begin @(posedge clk); #1; end
    chk("drop_count", drops_seen, drops_exp);
    chk("out_count",  outs_seen,  8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
